// File: rtl/clb_pkg.sv
// Shared CLB definitions: default LUT geometry and the truth-table/select types
// used by the logic cells and the programming chain.
package clb_pkg;

   localparam int CLB_LUT_K_DEFAULT = 4;
   localparam int CLB_LUT_W_DEFAULT = 16;

   typedef logic [CLB_LUT_W_DEFAULT-1:0] lut_cfg_t;
   typedef logic [CLB_LUT_K_DEFAULT-1:0] lut_sel_t;

endpackage : clb_pkg

// File: rtl/clb_lut_mux.sv
// 2^LUT_K:1 truth-table selector built as a binary mux tree.
// Level 0 is the raw table; each next level halves it using one select bit, LSB first.
module clb_lut_mux
   import clb_pkg::*;
#(
   parameter int LUT_K = CLB_LUT_K_DEFAULT
) (
   input  logic [LUT_K-1:0]      lut_sel,
   input  logic [(1<<LUT_K)-1:0] lut_cfg,
   output logic                  lut_out
);

   localparam int LUT_W = 1 << LUT_K;

   for (genvar l = 0; l <= LUT_K; l++) begin : g_lvl
      logic [(LUT_W >> l)-1:0] node;
      if (l == 0) begin : g_leaf
         assign node = lut_cfg;
      end else begin : g_node
         for (genvar i = 0; i < (LUT_W >> l); i++) begin : g_mux
            assign node[i] = lut_sel[l-1] ? g_lvl[l-1].node[2*i+1] : g_lvl[l-1].node[2*i];
         end
      end
   end

   assign lut_out = g_lvl[LUT_K].node[0];

endmodule : clb_lut_mux

// File: rtl/clb_lut_ff_cell.sv
// CLB logic cell: K-input LUT, D flip-flop and combinational/registered output mux.
// Define CLB_FF_CE_EN to add a clock-enable input (ff_ce) on the flip-flop.
module clb_lut_ff_cell
   import clb_pkg::*;
#(
   parameter int   LUT_K        = CLB_LUT_K_DEFAULT,
   parameter logic FF_RESET_VAL = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef CLB_FF_CE_EN
   input  logic                  ff_ce,
`endif
   input  logic [LUT_K-1:0]      lut_sel,
   input  logic [(1<<LUT_K)-1:0] lut_cfg,
   input  logic                  out_sel,
   output logic                  lut_out,
   output logic                  ff_out,
   output logic                  cell_out
);

   logic ff_d;
   logic ff_q;

   clb_lut_mux #(
      .LUT_K (LUT_K)
   ) u_lut (
      .lut_sel (lut_sel),
      .lut_cfg (lut_cfg),
      .lut_out (lut_out)
   );

   always_comb begin
`ifdef CLB_FF_CE_EN
      ff_d = ff_q;
      if (ff_ce) begin
         ff_d = lut_out;
      end
`else
      ff_d = lut_out;
`endif
   end

   // Reset is deliberately not synchronised here; the CLB reset tree handles release timing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff_q <= FF_RESET_VAL;
      end else begin
         ff_q <= ff_d;
      end
   end

   assign ff_out   = ff_q;
   assign cell_out = out_sel ? ff_q : lut_out;

endmodule : clb_lut_ff_cell

// File: tb/tb_clb_lut_ff_cell.sv
// Directed self-checking bench for clb_lut_ff_cell (default LUT_K=4, FF_RESET_VAL=0).
// Also exercises the clock enable when CLB_FF_CE_EN is defined.
module tb_clb_lut_ff_cell;
   import clb_pkg::*;

   logic     clk;
   logic     rst_n;
   lut_sel_t lut_sel;
   lut_cfg_t lut_cfg;
   logic     out_sel;
   logic     lut_out;
   logic     ff_out;
   logic     cell_out;
`ifdef CLB_FF_CE_EN
   logic     ff_ce;
`endif

   int vectors;
   int miscompares;

   clb_lut_ff_cell #(
      .LUT_K        (4),
      .FF_RESET_VAL (1'b0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef CLB_FF_CE_EN
      .ff_ce    (ff_ce),
`endif
      .lut_sel  (lut_sel),
      .lut_cfg  (lut_cfg),
      .out_sel  (out_sel),
      .lut_out  (lut_out),
      .ff_out   (ff_out),
      .cell_out (cell_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n   = 1'b0;
      lut_cfg = 16'hFFFF;
      lut_sel = 4'd0;
      out_sel = 1'b1;
      #1;
      vectors++;
      if (ff_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ff_initial: got %b expected 0", ff_out);
      end
      vectors++;
      if (cell_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_cell_initial: got %b expected 0", cell_out);
      end
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (ff_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ff_hold[%0d]: got %b expected 0", n, ff_out);
         end
         vectors++;
         if (cell_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_cell_hold[%0d]: got %b expected 0", n, cell_out);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (ff_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_release_no_edge: got %b expected 0", ff_out);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (ff_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_first_capture: got %b expected 1", ff_out);
      end
   endtask

   task automatic test_lut_sweep();
      logic [0:15] expected;
      expected = 16'b1100_0011_1010_0101;
      @(negedge clk);
      lut_cfg = 16'hA5C3;
      out_sel = 1'b0;
      for (int i = 0; i < 16; i++) begin
         lut_sel = 4'(i);
         #1;
         vectors++;
         if (lut_out !== expected[i]) begin
            miscompares++;
            $display("[TB] FAIL lut_sweep_lut_out[%0d]: got %b expected %b", i, lut_out, expected[i]);
         end
         vectors++;
         if (cell_out !== expected[i]) begin
            miscompares++;
            $display("[TB] FAIL lut_sweep_cell_out[%0d]: got %b expected %b", i, cell_out, expected[i]);
         end
      end
   endtask

   task automatic test_register_latency();
      @(negedge clk);
      lut_cfg = 16'h0002;
      out_sel = 1'b1;
      lut_sel = 4'd0;
      @(posedge clk);
      #1;
      vectors++;
      if (cell_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL latency_pre_zero: got %b expected 0", cell_out);
      end
      @(negedge clk);
      lut_sel = 4'd1;
      #1;
      vectors++;
      if (cell_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL latency_before_edge: got %b expected 0", cell_out);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (cell_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL latency_after_edge: got %b expected 1", cell_out);
      end
      @(negedge clk);
      lut_sel = 4'd0;
      #1;
      vectors++;
      if (cell_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL latency_hold_midcycle: got %b expected 1", cell_out);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (cell_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL latency_next_edge: got %b expected 0", cell_out);
      end
   endtask

   task automatic test_output_mux();
      @(negedge clk);
      lut_cfg = 16'h0002;
      lut_sel = 4'd1;
      @(posedge clk);
      @(negedge clk);
      lut_sel = 4'd0;
      out_sel = 1'b0;
      #1;
      vectors++;
      if (cell_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mux_sel_lut: got %b expected 0", cell_out);
      end
      out_sel = 1'b1;
      #1;
      vectors++;
      if (cell_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL mux_sel_ff: got %b expected 1", cell_out);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      lut_cfg = 16'h0002;
      lut_sel = 4'd1;
      out_sel = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (ff_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL async_setup: got %b expected 1", ff_out);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (ff_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL async_ff_clear: got %b expected 0", ff_out);
      end
      vectors++;
      if (cell_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL async_cell_clear: got %b expected 0", cell_out);
      end
      vectors++;
      if (lut_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL async_lut_unaffected: got %b expected 1", lut_out);
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (ff_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL async_release_hold: got %b expected 0", ff_out);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (ff_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL async_recapture: got %b expected 1", ff_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] sel_seq [5];
      logic       exp_seq [5];
      sel_seq = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd0};
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      lut_cfg = 16'h0002;
      out_sel = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         lut_sel = sel_seq[i];
         @(posedge clk);
         #1;
         vectors++;
         if (ff_out !== exp_seq[i]) begin
            miscompares++;
            $display("[TB] FAIL back_to_back[%0d]: got %b expected %b", i, ff_out, exp_seq[i]);
         end
      end
   endtask

`ifdef CLB_FF_CE_EN
   task automatic test_clock_enable();
      @(negedge clk);
      lut_cfg = 16'h0002;
      lut_sel = 4'd0;
      @(posedge clk);
      @(negedge clk);
      ff_ce   = 1'b0;
      lut_sel = 4'd1;
      for (int n = 0; n < 2; n++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (ff_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ce_hold[%0d]: got %b expected 0", n, ff_out);
         end
      end
      @(negedge clk);
      ff_ce = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (ff_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ce_capture: got %b expected 1", ff_out);
      end
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
`ifdef CLB_FF_CE_EN
      ff_ce = 1'b1;
`endif
      test_reset();
      test_lut_sweep();
      test_register_latency();
      test_output_mux();
      test_async_reset();
      test_back_to_back();
`ifdef CLB_FF_CE_EN
      test_clock_enable();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_clb_lut_ff_cell
